// File: rtl/rename_reg_file_pkg.sv
// Shared configuration for the rename register file: data/tag/index widths,
// the hardwired-zero register index and a popcount helper for pending tags.
package rename_reg_file_pkg;

   localparam int XLEN         = 32;
   localparam int NUM_REGS     = 32;
   localparam int REG_ID_W     = $clog2(NUM_REGS);
   localparam int ROB_SIZE_BIT = 4;

   localparam logic [REG_ID_W-1:0] REG_ZERO = {REG_ID_W{1'b0}};

   // Number of set bits in a per-register flag vector.
   function automatic logic [REG_ID_W:0] popcount(input logic [NUM_REGS-1:0] bits);
      logic [REG_ID_W:0] cnt;
      cnt = {(REG_ID_W+1){1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt = cnt + {{REG_ID_W{1'b0}}, bits[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/rename_reg_file_rf_query_port.sv
// One combinational read port of the rename register file. Returns the stored
// value/tag of the queried register, with the same-cycle commit forwarded so the
// Decoder sees a value the ROB is retiring right now.
module rf_query_port
   import rename_reg_file_pkg::*;
(
   input  logic                                   rdy_in,
   input  logic                                   commit_valid,
   input  logic [REG_ID_W-1:0]                    commit_rd,
   input  logic [ROB_SIZE_BIT-1:0]                commit_rob_id,
   input  logic [XLEN-1:0]                        commit_val,
   input  logic [NUM_REGS-1:0][XLEN-1:0]          val_tbl,
   input  logic [NUM_REGS-1:0][ROB_SIZE_BIT-1:0]  dep_tbl,
   input  logic [NUM_REGS-1:0]                    has_dep_tbl,
   input  logic [REG_ID_W-1:0]                    qry_id,
   output logic [XLEN-1:0]                        qry_val,
   output logic [ROB_SIZE_BIT-1:0]                qry_dep,
   output logic                                   qry_has_dep
);

   logic bypass_s;

   // Read the indexed entry; a live commit to the same register overrides the
   // value and retires the dependency only if its tag is still the current one.
   always_comb begin
      bypass_s = commit_valid && rdy_in && (commit_rd == qry_id) && (qry_id != REG_ZERO);
      if (qry_id == REG_ZERO) begin
         qry_val     = {XLEN{1'b0}};
         qry_dep     = {ROB_SIZE_BIT{1'b0}};
         qry_has_dep = 1'b0;
      end else if (bypass_s) begin
         qry_val     = commit_val;
         qry_dep     = dep_tbl[qry_id];
         qry_has_dep = has_dep_tbl[qry_id] && (dep_tbl[qry_id] != commit_rob_id);
      end else begin
         qry_val     = val_tbl[qry_id];
         qry_dep     = dep_tbl[qry_id];
         qry_has_dep = has_dep_tbl[qry_id];
      end
   end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register ROB dependency tags.
// Decoder renames set a tag, ROB commits write the value and clear a matching
// tag, and a flush drops every tag at once. Reads go through rf_query_port.
module rename_reg_file
   import rename_reg_file_pkg::*;
#(
   parameter int NUM_RD_PORTS = 2
)
(
   input  logic                                 clk_in,
   input  logic                                 rst_in,
   input  logic                                 rdy_in,
   input  logic                                 commit_valid,
   input  logic [REG_ID_W-1:0]                  commit_rd,
   input  logic [ROB_SIZE_BIT-1:0]              commit_rob_id,
   input  logic [XLEN-1:0]                      commit_val,
   input  logic                                 rename_valid,
   input  logic [REG_ID_W-1:0]                  rename_rd,
   input  logic [ROB_SIZE_BIT-1:0]              rename_rob_id,
   input  logic                                 flush,
   input  logic [NUM_RD_PORTS*REG_ID_W-1:0]     qry_id,
   output logic [NUM_RD_PORTS*XLEN-1:0]         qry_val,
   output logic [NUM_RD_PORTS*ROB_SIZE_BIT-1:0] qry_dep,
   output logic [NUM_RD_PORTS-1:0]              qry_has_dep,
   output logic [REG_ID_W:0]                    pending_cnt
);

   logic [NUM_REGS-1:0][XLEN-1:0]         val_r;
   logic [NUM_REGS-1:0][XLEN-1:0]         val_nxt_s;
   logic [NUM_REGS-1:0][ROB_SIZE_BIT-1:0] dep_r;
   logic [NUM_REGS-1:0][ROB_SIZE_BIT-1:0] dep_nxt_s;
   logic [NUM_REGS-1:0]                   has_dep_r;
   logic [NUM_REGS-1:0]                   has_dep_nxt_s;
   logic [NUM_REGS-1:0]                   commit_sel_s;
   logic [NUM_REGS-1:0]                   rename_sel_s;
   logic [REG_ID_W:0]                     pending_cnt_r;
   logic [REG_ID_W:0]                     cnt_nxt_s;
   logic                                  commit_hit_s;
   logic                                  rename_hit_s;

   // Next-state of every register: flush beats rename, rename beats a commit
   // clear, and the commit value write always lands. Register 0 stays zero.
   always_comb begin
      commit_hit_s     = commit_valid && (commit_rd != REG_ZERO);
      rename_hit_s     = rename_valid && (rename_rd != REG_ZERO) && !flush;
      commit_sel_s     = {NUM_REGS{1'b0}};
      rename_sel_s     = {NUM_REGS{1'b0}};
      val_nxt_s        = val_r;
      dep_nxt_s        = dep_r;
      has_dep_nxt_s    = has_dep_r;
      val_nxt_s[0]     = {XLEN{1'b0}};
      dep_nxt_s[0]     = {ROB_SIZE_BIT{1'b0}};
      has_dep_nxt_s[0] = 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
         commit_sel_s[i] = commit_hit_s && (commit_rd == REG_ID_W'(i));
         rename_sel_s[i] = rename_hit_s && (rename_rd == REG_ID_W'(i));
         val_nxt_s[i]    = commit_sel_s[i] ? commit_val : val_r[i];
         dep_nxt_s[i]    = rename_sel_s[i] ? rename_rob_id : dep_r[i];
         if (flush) begin
            has_dep_nxt_s[i] = 1'b0;
         end else if (rename_sel_s[i]) begin
            has_dep_nxt_s[i] = 1'b1;
         end else if (commit_sel_s[i] && has_dep_r[i] && (dep_r[i] == commit_rob_id)) begin
            has_dep_nxt_s[i] = 1'b0;
         end else begin
            has_dep_nxt_s[i] = has_dep_r[i];
         end
      end
      cnt_nxt_s = popcount(has_dep_nxt_s);
   end

   // State update: reset wins over everything, rdy_in low freezes the file.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         val_r         <= {(NUM_REGS*XLEN){1'b0}};
         dep_r         <= {(NUM_REGS*ROB_SIZE_BIT){1'b0}};
         has_dep_r     <= {NUM_REGS{1'b0}};
         pending_cnt_r <= {(REG_ID_W+1){1'b0}};
      end else if (rdy_in) begin
         val_r         <= val_nxt_s;
         dep_r         <= dep_nxt_s;
         has_dep_r     <= has_dep_nxt_s;
         pending_cnt_r <= cnt_nxt_s;
      end else begin
         val_r         <= val_r;
         dep_r         <= dep_r;
         has_dep_r     <= has_dep_r;
         pending_cnt_r <= pending_cnt_r;
      end
   end

   assign pending_cnt = pending_cnt_r;

   for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_port
      rf_query_port u_port (
         .rdy_in        (rdy_in),
         .commit_valid  (commit_valid),
         .commit_rd     (commit_rd),
         .commit_rob_id (commit_rob_id),
         .commit_val    (commit_val),
         .val_tbl       (val_r),
         .dep_tbl       (dep_r),
         .has_dep_tbl   (has_dep_r),
         .qry_id        (qry_id[k*REG_ID_W +: REG_ID_W]),
         .qry_val       (qry_val[k*XLEN +: XLEN]),
         .qry_dep       (qry_dep[k*ROB_SIZE_BIT +: ROB_SIZE_BIT]),
         .qry_has_dep   (qry_has_dep[k])
      );
   end

endmodule
